// File: rtl/sprite_motion.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_motion
//  Purpose  : Per-frame sprite position controller feeding sprite_v3. During
//             vertical blanking it steps the sprite by a fixed velocity and
//             bounces it off the active-area edges, then issues a one-cycle
//             start pulse on the blanking line before the sprite's first line.
//  Ports    : clk        pixel clock
//             rst_n      synchronous reset, active-low
//             en         motion enable, sampled at the update point
//             sx, sy     current screen position from display_timings
//             sprx, spry committed sprite left edge / top line
//             spr_start  registered one-cycle start pulse to the engine
//             bounce     one-cycle pulse when either axis reverses
//  Revision : 1.0  initial release
// ============================================================================
module sprite_motion #(
  parameter int CORDW      = 10,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int V_RES_FULL = 525,
  parameter int SPR_W      = 80,
  parameter int SPR_H      = 80,
  parameter int START_X    = 280,
  parameter int START_Y    = 200,
  parameter int SPEED_X    = 2,
  parameter int SPEED_Y    = 1,
  parameter int FRAME_DIV  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  output logic [CORDW-1:0] sprx,
  output logic [CORDW-1:0] spry,
  output logic             spr_start,
  output logic             bounce
);

  localparam logic [CORDW-1:0] c_x_max   = CORDW'(H_RES - SPR_W);
  localparam logic [CORDW-1:0] c_y_max   = CORDW'(V_RES - SPR_H);
  localparam logic [CORDW-1:0] c_spd_x   = CORDW'(SPEED_X);
  localparam logic [CORDW-1:0] c_spd_y   = CORDW'(SPEED_Y);
  localparam logic [CORDW-1:0] c_h_res   = CORDW'(H_RES);
  localparam logic [CORDW-1:0] c_v_res   = CORDW'(V_RES);
  localparam logic [CORDW-1:0] c_ls_wrap = CORDW'(V_RES_FULL - 1);
  localparam logic [CORDW-1:0] c_one     = CORDW'(1);
  localparam logic [CORDW-1:0] c_start_x = CORDW'(START_X);
  localparam logic [CORDW-1:0] c_start_y = CORDW'(START_Y);
  localparam logic [7:0]       c_div_last = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_MOVE_X = 2'd1,
    ST_MOVE_Y = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t           r_state;
  logic [7:0]       r_frame_cnt;
  logic             r_dir_x;      // 1 = moving right
  logic             r_dir_y;      // 1 = moving down
  logic [CORDW-1:0] r_nx;         // shadow position, committed in ST_COMMIT
  logic [CORDW-1:0] r_ny;
  logic             r_ndx;        // shadow directions
  logic             r_ndy;

  // One extra bit so the forward step never wraps before the limit compare.
  logic [CORDW:0]   w_tx;
  logic [CORDW:0]   w_ty;
  logic             w_upd;
  logic [CORDW-1:0] w_ls;

  assign w_tx  = {1'b0, sprx} + {1'b0, c_spd_x};
  assign w_ty  = {1'b0, spry} + {1'b0, c_spd_y};
  assign w_upd = (sy == c_v_res) && (sx == '0);
  // Start line precedes the sprite's top line; top line 0 wraps to the last
  // blanking line of the previous frame.
  assign w_ls  = (spry == '0) ? c_ls_wrap : (spry - c_one);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_WAIT;
      r_frame_cnt <= '0;
      r_dir_x     <= 1'b1;
      r_dir_y     <= 1'b1;
      r_nx        <= c_start_x;
      r_ny        <= c_start_y;
      r_ndx       <= 1'b1;
      r_ndy       <= 1'b1;
      sprx        <= c_start_x;
      spry        <= c_start_y;
      spr_start   <= 1'b0;
      bounce      <= 1'b0;
    end else begin
      bounce    <= 1'b0;
      spr_start <= (sy == w_ls) && (sx == c_h_res);

      case (r_state)
        ST_WAIT: begin
          if (w_upd) begin
            if (r_frame_cnt == c_div_last) begin
              r_frame_cnt <= '0;
              if (en) r_state <= ST_MOVE_X;
            end else begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
        end

        ST_MOVE_X: begin
          if (r_dir_x) begin
            if (w_tx > {1'b0, c_x_max}) begin
              r_nx  <= c_x_max;
              r_ndx <= 1'b0;
            end else begin
              r_nx  <= w_tx[CORDW-1:0];
              r_ndx <= 1'b1;
            end
          end else begin
            if (sprx < c_spd_x) begin
              r_nx  <= '0;
              r_ndx <= 1'b1;
            end else begin
              r_nx  <= sprx - c_spd_x;
              r_ndx <= 1'b0;
            end
          end
          r_state <= ST_MOVE_Y;
        end

        ST_MOVE_Y: begin
          if (r_dir_y) begin
            if (w_ty > {1'b0, c_y_max}) begin
              r_ny  <= c_y_max;
              r_ndy <= 1'b0;
            end else begin
              r_ny  <= w_ty[CORDW-1:0];
              r_ndy <= 1'b1;
            end
          end else begin
            if (spry < c_spd_y) begin
              r_ny  <= '0;
              r_ndy <= 1'b1;
            end else begin
              r_ny  <= spry - c_spd_y;
              r_ndy <= 1'b0;
            end
          end
          r_state <= ST_COMMIT;
        end

        ST_COMMIT: begin
          sprx    <= r_nx;
          spry    <= r_ny;
          // A corner hit flips both axes but still yields a single pulse.
          bounce  <= (r_ndx != r_dir_x) || (r_ndy != r_dir_y);
          r_dir_x <= r_ndx;
          r_dir_y <= r_ndy;
          r_state <= ST_WAIT;
        end

        default: r_state <= ST_WAIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sprite_motion.md
Name: sprite_motion

Overview:
- Position controller directly upstream of the sprite engine (sprite_v3).
- Once per frame, during vertical blanking, moves a sprite by a fixed velocity and bounces it off the active-area edges.
- Drives the engine's horizontal position (sprx) plus a registered one-cycle start pulse on the blanking line before the sprite's first line.
- sprx/spry are stable throughout active video, so the image never tears.

Parameters:
- CORDW, 10, coordinate width in bits (sx, sy, sprx, spry).
- H_RES, 640, active pixels per line.
- V_RES, 480, active lines.
- V_RES_FULL, 525, total lines including blanking.
- SPR_W, 80, on-screen sprite width in pixels (WIDTH*SCALE_X).
- SPR_H, 80, on-screen sprite height in lines (HEIGHT*SCALE_Y).
- START_X, 280, reset X position.
- START_Y, 200, reset Y position.
- SPEED_X, 2, X pixels moved per update, 1..SPR_W.
- SPEED_Y, 1, Y lines moved per update, 1..SPR_H.
- FRAME_DIV, 1, frames per position update, 1..255.

Ports:
- clk, input, 1, pixel clock.
- rst_n, input, 1, synchronous reset, active-low.
- en, input, 1, motion enable, sampled at the update point.
- sx, input, CORDW, current horizontal screen position from display_timings.
- sy, input, CORDW, current vertical screen position from display_timings.
- sprx, output, CORDW, sprite left edge.
- spry, output, CORDW, sprite top line.
- spr_start, output, 1, one-cycle start pulse to the sprite engine.
- bounce, output, 1, one-cycle pulse when either axis reverses direction.

Behaviour:
- Reset (rst_n low at a clk edge):
  - sprx=START_X, spry=START_Y; internal direction right and down.
  - Frame counter=0, FSM=WAIT, spr_start=0, bounce=0.
  - Reset mid-update abandons the update; no partial position is committed.
- Update point: the single cycle with sy==V_RES && sx==0.
- FSM states and transitions:
  - WAIT: at the update point, increment the frame counter.
    - If the counter reaches FRAME_DIV-1: clear it. If en=1, go to MOVE_X; otherwise stay in WAIT with no position change.
    - Otherwise stay in WAIT.
  - MOVE_X (1 cycle): compute nx into a shadow register, then go to MOVE_Y.
  - MOVE_Y (1 cycle): compute ny into a shadow register, then go to COMMIT.
  - COMMIT (1 cycle): copy the shadows to sprx/spry, pulse bounce if either direction flipped this update, then go to WAIT.
  - sprx/spry change exactly 3 cycles after the update point, always inside vertical blanking.
- X arithmetic (CORDW+1 bits, no overflow):
  - Moving right: t=x+SPEED_X. If t > H_RES-SPR_W, then x=H_RES-SPR_W and direction becomes left; else x=t.
  - Moving left: if x < SPEED_X, then x=0 and direction becomes right; else x=x-SPEED_X.
  - Landing exactly on an edge does not flip direction; the flip happens on the next attempt past it.
- Y arithmetic: same rules, using V_RES-SPR_H and SPEED_Y.
- Simultaneous X and Y flips (corner hit) produce a single bounce pulse.
- spr_start:
  - Trigger line ls = (spry==0) ? V_RES_FULL-1 : spry-1.
  - spr_start is registered: high for exactly one cycle, the cycle after sy==ls && sx==H_RES.
  - Generated every frame regardless of en.
  - Uses the committed spry only.
- Legality (not checked in RTL): START_X ≤ H_RES-SPR_W, START_Y ≤ V_RES-SPR_H, SPR_W<H_RES, SPR_H<V_RES.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset hold 5 cycles, release, run 1 frame with en=0 -> sprx=280, spry=200; spr_start pulses once, in the cycle after sy=199, sx=640; bounce never asserts.
2. en=1, defaults, 3 frames -> after each update point, sprx 282/284/286 and spry 201/202/203; each change lands exactly 3 cycles after sy=480, sx=0.
3. START_X=556, SPEED_X=2 -> update 1: sprx=558 (no flip); update 2: t=560 equals the limit, so sprx=560 (no flip); update 3: t=562 exceeds the limit, so sprx=560, direction flips left, bounce pulses; update 4: sprx=558.
4. START_X=1, START_Y=0, direction forced left/up via prior bounces -> x clamps to 0 and y clamps to 0, with exactly one bounce pulse for the corner; with spry=0, spr_start fires on sy=524.
5. FRAME_DIV=3, en=1 -> sprx advances only on every third update point (280, 280, 282 after frames 1–3); dropping en for frame 6 skips that step.
6. Assert rst_n low for 1 cycle while the FSM is in MOVE_Y -> next cycle sprx=280, spry=200, bounce=0, FSM=WAIT; the next update proceeds normally.
